dmem_write_buffer: RTL and testbench

//   Data-memory responder for the single-cycle datapath's load/store port (DataAdr, WriteData, ReadData).

---
 rtl/dmem_write_buffer.sv | 67 ++++++
 tb/tb_dmem_write_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store FIFO in front of a single-ported word array, with youngest-match load forwarding
module dmem_write_buffer #(
    parameter int MEM_WORDS = 64,
    parameter int WB_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy,
    output logic        wb_empty,
    output logic        err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam logic [PW:0] FULL = WB_DEPTH[PW:0];
    logic [AW-1:0] idx_q [WB_DEPTH];
    logic [31:0]   dat_q [WB_DEPTH];
    logic [31:0]   mem   [MEM_WORDS];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic [AW-1:0] index;
    logic          push, drain;
    logic          unused_addr;
    assign index       = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign busy        = count == FULL;
    assign wb_empty    = count == '0;
    assign push        = we && !busy;
    assign drain       = !wb_empty && !re;
    // walk oldest to youngest so the last hit is the youngest matching store
    always_comb begin
        rd = '0;
        if (re) begin
            rd = mem[index];
            for (int i = 0; i < WB_DEPTH; i++)
                if ((PW+1)'(i) < count && idx_q[head + PW'(i)] == index)
                    rd = dat_q[head + PW'(i)];
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[tail] <= index;
            dat_q[tail] <= wd;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
            for (int j = 0; j < MEM_WORDS; j++) mem[j] <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (drain) begin
                mem[idx_q[head]] <= dat_q[head];
                head             <= head + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
            if (we && busy) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: randomized and directed checks against a queue-based store-buffer model
module tb_dmem_write_buffer;
    localparam int MW = 64;
    localparam int WD = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic [31:0] rd;
    logic        busy, wb_empty, err;
    int          checks = 0;
    int          errors = 0;

    dmem_write_buffer #(.MEM_WORDS(MW), .WB_DEPTH(WD)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wd(wd),
        .rd(rd), .busy(busy), .wb_empty(wb_empty), .err(err)
    );

    always #5 clk = ~clk;

    // reference model: FIFO of pending stores plus a plain word array
    typedef struct {
        int          idx;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    logic [31:0] mm [MW];
    logic        merr;
    logic        m_full;
    ent_t        m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            merr = 1'b0;
            foreach (mm[j]) mm[j] = '0;
        end else begin
            m_full = q.size() == WD;
            if (q.size() > 0 && !re) begin
                mm[q[0].idx] = q[0].d;
                void'(q.pop_front());
            end
            if (we && !m_full) begin
                m_e.idx = int'((addr / 4) % MW);
                m_e.d   = wd;
                q.push_back(m_e);
            end
            if (we && m_full) merr = 1'b1;
        end
    end

    function automatic logic [31:0] m_rd();
        logic [31:0] r;
        int          i;
        if (!re) return '0;
        i = int'((addr / 4) % MW);
        r = mm[i];
        foreach (q[k]) if (q[k].idx == i) r = q[k].d;
        return r;
    endfunction

    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; re = r; addr = a; wd = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        we = 0; re = 0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        step(0, 0, 0, 0);
        while (!wb_empty && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL drain_timeout wb_empty=%b exp=1", wb_empty); end
    endtask

    task automatic test_reset();
        re = 1'b1; addr = 32'h10;
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", wb_empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 32'h3C, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_after got=%h exp=0", rd); end
    endtask

    task automatic test_store_load();
        step(1, 0, 32'h10, 32'hDEADBEEF);
        step(0, 1, 32'h10, 0);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_rd got=%h exp=deadbeef", rd); end
        checks++; if (wb_empty !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fwd_count empty=%b busy=%b exp=0 0", wb_empty, busy); end
        drain_all();
        step(0, 1, 32'h10, 0);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL array_rd got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_youngest();
        step(1, 1, 32'h20, 32'h11);
        step(1, 1, 32'h20, 32'h22);
        step(1, 1, 32'h24, 32'h33);
        step(0, 1, 32'h20, 0);
        checks++; if (rd !== 32'h22) begin errors++; $display("FAIL youngest_rd got=%h exp=22", rd); end
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h20, 0);
        checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL youngest_empty got=%b exp=1", wb_empty); end
        checks++; if (rd !== 32'h22) begin errors++; $display("FAIL youngest_array got=%h exp=22", rd); end
        step(0, 1, 32'h24, 0);
        checks++; if (rd !== 32'h33) begin errors++; $display("FAIL youngest_other got=%h exp=33", rd); end
    endtask

    task automatic test_wrap();
        step(1, 0, MW * 4 + 32'h8, 32'hA5);
        drain_all();
        step(0, 1, 32'h8, 0);
        checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL wrap_rd got=%h exp=a5", rd); end
        step(0, 1, 32'hB, 0);
        checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL wrap_lowbits got=%h exp=a5", rd); end
        step(0, 0, 32'h8, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_no_re got=%h exp=0", rd); end
    endtask

    task automatic test_push_drain();
        logic [31:0] vals [2*WD+2];
        foreach (vals[k]) vals[k] = $urandom;
        step(1, 1, 32'h40, vals[0]);
        step(1, 1, 32'h44, vals[1]);
        for (int k = 0; k < 2 * WD; k++) begin
            step(1, 0, 32'h48 + 4 * k, vals[k+2]);
            checks++; if (busy !== 1'b0 || wb_empty !== 1'b0) begin errors++; $display("FAIL pd_count%0d busy=%b empty=%b exp=0 0", k, busy, wb_empty); end
        end
        drain_all();
        for (int k = 0; k < 2 * WD + 2; k++) begin
            step(0, 1, 32'h40 + 4 * k, 0);
            checks++; if (rd !== vals[k]) begin errors++; $display("FAIL pd_data%0d got=%h exp=%h", k, rd, vals[k]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = $urandom & 32'hFFFF_FF03;
            a[4:2] = 3'($urandom_range(0, 7));
            step(1'($urandom % 2), $urandom_range(0, 3) != 0, a, $urandom);
            checks++; if (rd !== m_rd()) begin errors++; $display("FAIL rand_rd%0d got=%h exp=%h", n, rd, m_rd()); end
            checks++; if (busy !== (q.size() == WD)) begin errors++; $display("FAIL rand_busy%0d got=%b exp=%b", n, busy, q.size() == WD); end
            checks++; if (wb_empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty%0d got=%b exp=%b", n, wb_empty, q.size() == 0); end
            checks++; if (err !== merr) begin errors++; $display("FAIL rand_err%0d got=%b exp=%b", n, err, merr); end
        end
        drain_all();
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 1; k <= WD; k++) step(1, 1, 32'(4 * k), 32'(k));
        step(0, 1, 32'h4, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_pre got=%b exp=0", err); end
        step(1, 1, 32'h0, 32'h55);
        step(0, 1, 32'h0, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL full_err got=%b exp=1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL full_drop_rd got=%h exp=0", rd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_hold got=%b exp=1", busy); end
        step(0, 1, 32'h8, 0);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL full_contents got=%h exp=2", rd); end
        step(1, 0, 32'h0, 32'h66);
        step(0, 1, 32'h0, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL full_drain_drop got=%h exp=0", rd); end
        checks++; if (busy !== 1'b0 || wb_empty !== 1'b0) begin errors++; $display("FAIL full_drain_count busy=%b empty=%b exp=0 0", busy, wb_empty); end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 32'h40, 32'h1234);
        step(1, 1, 32'h44, 32'h5678);
        @(negedge clk);
        we = 0; re = 0;
        checks++; if (wb_empty !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL mid_pre empty=%b err=%b exp=0 1", wb_empty, err); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || wb_empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mid_reset busy=%b empty=%b err=%b exp=0 1 0", busy, wb_empty, err); end
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 32'h40, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rd40 got=%h exp=0", rd); end
        step(0, 1, 32'h44, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rd44 got=%h exp=0", rd); end
        step(0, 1, 32'h8, 0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rd8 got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_youngest();
        test_wrap();
        test_push_drain();
        test_random();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
